// File: rtl/reflex_trial_fsm_pkg.sv
// Shared definitions for the reflex trial game: state encoding, LFSR constants
// and the error lockout threshold shared with count_errors.
package reflex_trial_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_LIT   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Error count at which new trials are refused
    localparam logic [1:0] MAX_ERRORS = 2'd3;

    // One shift step: feedback is the XOR of the tapped bits
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reflex_trial_fsm_lfsr16.sv
// Free-running 16-bit maximal-length LFSR; a non-zero seed keeps it out of the
// all-zero lock-up state.
module lfsr16
    import reflex_trial_fsm_pkg::*;
(
    input  logic        ck,
    input  logic        reset_n,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;

    // Advance one step every clock, including while the game is idle
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/reflex_trial_fsm.sv
// Reflex trial controller: random wait, lamp on, time the button press in ms.
// Early presses and timeouts pulse inc_errors; three errors lock out new trials.
module reflex_trial_fsm
    import reflex_trial_fsm_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_W       = 10,
    parameter int TIMEOUT_MS   = 2000,
    parameter int RT_W         = 12
) (
    input  logic            ck,
    input  logic            reset_n,
    input  logic            start,
    input  logic            button,
    input  logic [1:0]      error_count,
    output logic            led,
    output logic            busy,
    output logic            inc_errors,
    output logic            result_valid,
    output logic [RT_W-1:0] reaction_ms,
    output logic            locked
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = $clog2(MIN_DELAY_MS + (2 ** RAND_W)) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [RT_W-1:0]   TIMEOUT_V = RT_W'(TIMEOUT_MS);
    localparam logic [RT_W-1:0]   RT_MAX    = {RT_W{1'b1}};
    localparam logic [WAIT_W-1:0] MIN_WAIT  = WAIT_W'(MIN_DELAY_MS);
    localparam logic [15:0]       RAND_MASK = 16'((1 << RAND_W) - 1);

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [RT_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [RT_W-1:0]   reaction_q, reaction_d;
    logic              start_q, button_q;

    logic [15:0]       lfsr_q;
    logic              start_p, press_p, tick;
    logic [RT_W-1:0]   ms_inc;

    lfsr16 u_lfsr (
        .ck      (ck),
        .reset_n (reset_n),
        .q       (lfsr_q)
    );

    assign start_p = start & ~start_q;
    assign press_p = button & ~button_q;
    assign tick    = (tick_cnt_q == TICK_LAST);
    assign ms_inc  = (ms_cnt_q == RT_MAX) ? ms_cnt_q : ms_cnt_q + 1'b1;
    assign locked  = (error_count == MAX_ERRORS);

    // State register
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a press always wins over a same-cycle tick event
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_p && !locked) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (press_p)                    state_d = ST_ERR;
                else if (tick && wait_q <= 1)   state_d = ST_LIT;
            end
            ST_LIT: begin
                if (press_p)                    state_d = ST_DONE;
                else if (tick && ms_inc >= TIMEOUT_V) state_d = ST_ERR;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: tick divider, wait countdown, ms counter, result
    always_comb begin
        tick_cnt_d = (tick || state_d != state_q) ? '0 : tick_cnt_q + 1'b1;

        wait_d = wait_q;
        if (state_q == ST_IDLE && state_d == ST_ARMED) begin
            wait_d = MIN_WAIT + WAIT_W'(lfsr_q & RAND_MASK);
        end else if (state_q == ST_ARMED && tick && wait_q != '0) begin
            wait_d = wait_q - 1'b1;
        end

        ms_cnt_d = ms_cnt_q;
        if (state_q != ST_LIT && state_d == ST_LIT) begin
            ms_cnt_d = '0;
        end else if (state_q == ST_LIT && tick) begin
            ms_cnt_d = ms_inc;
        end

        // Load on the way into DONE so the value is valid alongside result_valid
        reaction_d = reaction_q;
        if (state_q == ST_LIT && state_d == ST_DONE) begin
            reaction_d = ms_cnt_q;
        end
    end

    // Datapath and input-edge registers
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            wait_q     <= '0;
            ms_cnt_q   <= '0;
            reaction_q <= '0;
            start_q    <= 1'b0;
            button_q   <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            wait_q     <= wait_d;
            ms_cnt_q   <= ms_cnt_d;
            reaction_q <= reaction_d;
            start_q    <= start;
            button_q   <= button;
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        led          = (state_q == ST_LIT);
        busy         = (state_q == ST_ARMED) || (state_q == ST_LIT);
        inc_errors   = (state_q == ST_ERR);
        result_valid = (state_q == ST_DONE);
        reaction_ms  = reaction_q;
    end

endmodule

// File: tb/tb_reflex_trial_fsm.sv
// Directed bench for reflex_trial_fsm with small timing parameters.
module tb_reflex_trial_fsm;

    localparam int RT_W = 12;

    logic            ck;
    logic            reset_n;
    logic            start;
    logic            button;
    logic [1:0]      error_count;
    logic            led;
    logic            busy;
    logic            inc_errors;
    logic            result_valid;
    logic [RT_W-1:0] reaction_ms;
    logic            locked;

    int checks = 0;
    int errors = 0;
    int n;

    reflex_trial_fsm #(
        .TICK_DIV     (4),
        .MIN_DELAY_MS (2),
        .RAND_W       (2),
        .TIMEOUT_MS   (5),
        .RT_W         (RT_W)
    ) dut (
        .ck           (ck),
        .reset_n      (reset_n),
        .start        (start),
        .button       (button),
        .error_count  (error_count),
        .led          (led),
        .busy         (busy),
        .inc_errors   (inc_errors),
        .result_valid (result_valid),
        .reaction_ms  (reaction_ms),
        .locked       (locked)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance k rising edges, then settle 1 time unit past the edge
    task automatic step(input int k);
        repeat (k) @(posedge ck);
        #1;
    endtask

    initial begin
        reset_n     = 1'b1;
        start       = 1'b0;
        button      = 1'b0;
        error_count = 2'd0;
        #2 reset_n  = 1'b0;
        step(2);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_inc", inc_errors, 0);
        check("rst_rv", result_valid, 0);
        check("rst_react", reaction_ms, 0);
        check("rst_locked", locked, 0);
        reset_n = 1'b1;
        step(2);

        // Good trial: press 3 ticks after the lamp
        start = 1'b1;
        step(1);
        check("t2_busy_armed", busy, 1);
        start = 1'b0;
        n = 0;
        while (led !== 1'b1 && n < 40) begin step(1); n++; end
        check("t2_led_on", led, 1);
        check("t2_armed_len", (n >= 8 && n <= 20 && n % 4 == 0), 1);
        step(12);
        check("t2_still_lit", led, 1);
        button = 1'b1;
        step(1);
        check("t2_rv", result_valid, 1);
        check("t2_react", reaction_ms, 3);
        check("t2_led_off", led, 0);
        check("t2_no_inc", inc_errors, 0);
        step(1);
        check("t2_rv_one", result_valid, 0);
        check("t2_idle", busy, 0);
        button = 1'b0;
        step(2);

        // Early press during ARMED
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t3_busy", busy, 1);
        step(2);
        check("t3_led_dark", led, 0);
        button = 1'b1;
        step(1);
        check("t3_inc", inc_errors, 1);
        check("t3_led", led, 0);
        check("t3_busy_off", busy, 0);
        step(1);
        check("t3_inc_one", inc_errors, 0);
        check("t3_react_kept", reaction_ms, 3);
        button = 1'b0;
        step(2);

        // Timeout: no press
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (led !== 1'b1 && n < 40) begin step(1); n++; end
        check("t4_led_on", led, 1);
        n = 0;
        while (led === 1'b1 && n < 40) begin step(1); n++; end
        check("t4_lit_len", n, 20);
        check("t4_inc", inc_errors, 1);
        check("t4_no_rv", result_valid, 0);
        step(1);
        check("t4_inc_one", inc_errors, 0);
        check("t4_idle", busy, 0);

        // Button pressed in IDLE and held; lockout then release
        button = 1'b1;
        step(2);
        check("t5_idle_press", busy, 0);
        error_count = 2'd3;
        #1;
        check("t5_locked", locked, 1);
        start = 1'b1;
        step(1);
        check("t5_refused", busy, 0);
        step(3);
        check("t5_still_idle", busy, 0);
        start = 1'b0;
        error_count = 2'd2;
        step(1);
        check("t5_unlocked", locked, 0);
        start = 1'b1;
        step(1);
        check("t5_accepted", busy, 1);
        start = 1'b0;

        // Held button through ARMED->LIT is not a press: times out
        n = 0;
        while (led !== 1'b1 && n < 40) begin step(1); n++; end
        check("t6_led_on", led, 1);
        n = 0;
        while (led === 1'b1 && n < 40) begin step(1); n++; end
        check("t6_lit_len", n, 20);
        check("t6_inc", inc_errors, 1);
        check("t6_react_kept", reaction_ms, 3);
        button = 1'b0;
        error_count = 2'd0;
        step(2);

        // Asynchronous reset in the middle of LIT
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (led !== 1'b1 && n < 40) begin step(1); n++; end
        check("t1_led_on", led, 1);
        step(5);
        reset_n = 1'b0;
        #1;
        check("t1_led", led, 0);
        check("t1_busy", busy, 0);
        check("t1_react", reaction_ms, 0);
        check("t1_inc", inc_errors, 0);
        check("t1_rv", result_valid, 0);
        step(1);
        check("t1_hold_busy", busy, 0);
        reset_n = 1'b1;
        step(2);
        check("t1_after_inc", inc_errors, 0);
        check("t1_after_rv", result_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
